serial_write_buffer: RTL and testbench

SERIAL_WRITE_BUFFER -- requirements
Module: serial_write_buffer

---
 rtl/serial_write_buffer_if.sv | 24 ++
 rtl/serial_write_buffer.sv | 95 +++++++++
 tb/tb_serial_write_buffer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_write_buffer_if.sv
// Handshake bundle between a serial write buffer and the logic that feeds it.
// The master supplies the word and the advance strobe; the slave drives the line.
interface serial_write_buffer_if #(
    parameter int BUF_SIZE = 8
);
    localparam int COUNT_WIDTH = $clog2(BUF_SIZE + 1);

    logic                   start;
    logic                   write_sig;
    logic [BUF_SIZE-1:0]    data_in;
    logic [COUNT_WIDTH-1:0] write_count;
    logic                   out_line;
    logic                   done_sig;

    modport master (
        output start, write_sig, data_in, write_count,
        input  out_line, done_sig
    );

    modport slave (
        input  start, write_sig, data_in, write_count,
        output out_line, done_sig
    );
endinterface

// File: rtl/serial_write_buffer.sv
// Parallel-to-serial write buffer: latches a word and presents it one bit at a
// time on out_line, advancing on each write_sig strobe until n bits have gone.
module serial_write_buffer #(
    parameter int BUF_SIZE  = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    serial_write_buffer_if.slave  bus
);
    localparam int COUNT_WIDTH = $clog2(BUF_SIZE + 1);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(BUF_SIZE);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [BUF_SIZE-1:0]    shift_reg;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic [COUNT_WIDTH-1:0] bit_total;
    logic                   out_bit;
    logic                   done_bit;

    logic [COUNT_WIDTH-1:0] clamped_count;
    logic [BUF_SIZE-1:0]    loaded_word;
    logic [BUF_SIZE-1:0]    advanced_word;
    logic [COUNT_WIDTH-1:0] next_count;

    // The bit on the line is always the head of the shift register, so for
    // MSB-first the word is pre-aligned so its top used bit sits at the MSB.
    function automatic logic head_bit(input logic [BUF_SIZE-1:0] word);
        if (LSB_FIRST != 0) begin
            return word[0];
        end
        return word[BUF_SIZE-1];
    endfunction

    always_comb begin
        clamped_count = (bus.write_count > MAX_COUNT) ? MAX_COUNT : bus.write_count;
        loaded_word   = bus.data_in;
        advanced_word = shift_reg << 1;
        if (LSB_FIRST == 0) begin
            loaded_word = bus.data_in << (MAX_COUNT - clamped_count);
        end else begin
            advanced_word = shift_reg >> 1;
        end
        next_count = bit_count + 1'b1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_count <= '0;
            bit_total <= '0;
            out_bit   <= 1'b0;
            done_bit  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= loaded_word;
                        bit_total <= clamped_count;
                        bit_count <= '0;
                        if (clamped_count != '0) begin
                            state    <= SHIFT;
                            out_bit  <= head_bit(loaded_word);
                            done_bit <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.write_sig) begin
                        bit_count <= next_count;
                        shift_reg <= advanced_word;
                        if (next_count == bit_total) begin
                            state    <= IDLE;
                            out_bit  <= 1'b0;
                            done_bit <= 1'b1;
                        end else begin
                            out_bit  <= head_bit(advanced_word);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    out_bit  <= 1'b0;
                    done_bit <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_line = out_bit;
    assign bus.done_sig = done_bit;
endmodule

// File: tb/tb_serial_write_buffer.sv
// Directed bench for serial_write_buffer: one MSB-first and one LSB-first
// instance, each scenario in its own task with hand-computed bit sequences.
module tb_serial_write_buffer;
    logic sys_clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    serial_write_buffer_if #(.BUF_SIZE(8)) msb_bus ();
    serial_write_buffer_if #(.BUF_SIZE(8)) lsb_bus ();

    serial_write_buffer #(.BUF_SIZE(8), .LSB_FIRST(0)) dut_msb (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (msb_bus.slave)
    );

    serial_write_buffer #(.BUF_SIZE(8), .LSB_FIRST(1)) dut_lsb (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (lsb_bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_compared += 4;
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_msb_out: got %b expected 0", msb_bus.out_line); end
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_msb_done: got %b expected 1", msb_bus.done_sig); end
        if (lsb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_lsb_out: got %b expected 0", lsb_bus.out_line); end
        if (lsb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_lsb_done: got %b expected 1", lsb_bus.done_sig); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_msb_transfer();
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_1010;
        msb_bus.data_in     = 8'h3a;
        msb_bus.write_count = 4'd8;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL msb_start_done: got %b expected 0", msb_bus.done_sig); end
        if (msb_bus.out_line !== exp_bits[7]) begin n_mismatched++; $display("[TB] FAIL msb_bit0: got %b expected %b", msb_bus.out_line, exp_bits[7]); end
        for (int i = 1; i < 8; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
            n_compared += 2;
            if (msb_bus.out_line !== exp_bits[7-i]) begin n_mismatched++; $display("[TB] FAIL msb_bit%0d: got %b expected %b", i, msb_bus.out_line, exp_bits[7-i]); end
            if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL msb_done_mid%0d: got %b expected 0", i, msb_bus.done_sig); end
            if (i == 3) begin
                repeat (4) step();
                n_compared++;
                if (msb_bus.out_line !== exp_bits[7-i]) begin n_mismatched++; $display("[TB] FAIL msb_gap_hold: got %b expected %b", msb_bus.out_line, exp_bits[7-i]); end
            end
        end
        msb_bus.write_sig = 1'b1;
        step();
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL msb_end_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL msb_end_out: got %b expected 0", msb_bus.out_line); end
        step();
    endtask

    task automatic test_reset_abort();
        logic [5:0] exp_bits;
        exp_bits = 6'b10_1010;
        msb_bus.data_in     = 8'h2a;
        msb_bus.write_count = 4'd6;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared++;
        if (msb_bus.out_line !== exp_bits[5]) begin n_mismatched++; $display("[TB] FAIL abort_bit0: got %b expected %b", msb_bus.out_line, exp_bits[5]); end
        for (int i = 1; i <= 3; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
            n_compared++;
            if (msb_bus.out_line !== exp_bits[5-i]) begin n_mismatched++; $display("[TB] FAIL abort_bit%0d: got %b expected %b", i, msb_bus.out_line, exp_bits[5-i]); end
        end
        #2;
        rst = 1'b1;
        #1;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abort_async_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_async_out: got %b expected 0", msb_bus.out_line); end
        #1;
        rst = 1'b0;
        msb_bus.write_sig = 1'b1;
        step();
        step();
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abort_after_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_after_out: got %b expected 0", msb_bus.out_line); end
        msb_bus.data_in     = 8'h0f;
        msb_bus.write_count = 4'd4;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared += 2;
        if (msb_bus.out_line !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fresh_bit0: got %b expected 1", msb_bus.out_line); end
        if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fresh_done_low: got %b expected 0", msb_bus.done_sig); end
        for (int i = 1; i < 4; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
            n_compared++;
            if (msb_bus.out_line !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fresh_bit%0d: got %b expected 1", i, msb_bus.out_line); end
        end
        msb_bus.write_sig = 1'b1;
        step();
        msb_bus.write_sig = 1'b0;
        n_compared++;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fresh_end_done: got %b expected 1", msb_bus.done_sig); end
        step();
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b0101_1100;
        lsb_bus.data_in     = 8'h3a;
        lsb_bus.write_count = 4'd8;
        lsb_bus.start       = 1'b1;
        step();
        lsb_bus.start = 1'b0;
        n_compared++;
        if (lsb_bus.out_line !== exp_bits[7]) begin n_mismatched++; $display("[TB] FAIL lsb_bit0: got %b expected %b", lsb_bus.out_line, exp_bits[7]); end
        for (int i = 1; i < 8; i++) begin
            lsb_bus.write_sig = 1'b1;
            step();
            lsb_bus.write_sig = 1'b0;
            step();
            n_compared++;
            if (lsb_bus.out_line !== exp_bits[7-i]) begin n_mismatched++; $display("[TB] FAIL lsb_bit%0d: got %b expected %b", i, lsb_bus.out_line, exp_bits[7-i]); end
        end
        lsb_bus.write_sig = 1'b1;
        step();
        lsb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (lsb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lsb_end_done: got %b expected 1", lsb_bus.done_sig); end
        if (lsb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lsb_end_out: got %b expected 0", lsb_bus.out_line); end
        step();
    endtask

    task automatic test_zero_count();
        msb_bus.data_in     = 8'hff;
        msb_bus.write_count = 4'd0;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_out: got %b expected 0", msb_bus.out_line); end
        step();
        n_compared++;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_done_later: got %b expected 1", msb_bus.done_sig); end
    endtask

    task automatic test_clamp();
        logic [7:0] exp_bits;
        exp_bits = 8'b1100_0101;
        msb_bus.data_in     = 8'hc5;
        msb_bus.write_count = 4'd12;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared++;
        if (msb_bus.out_line !== exp_bits[7]) begin n_mismatched++; $display("[TB] FAIL clamp_bit0: got %b expected %b", msb_bus.out_line, exp_bits[7]); end
        for (int i = 1; i < 8; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
            n_compared += 2;
            if (msb_bus.out_line !== exp_bits[7-i]) begin n_mismatched++; $display("[TB] FAIL clamp_bit%0d: got %b expected %b", i, msb_bus.out_line, exp_bits[7-i]); end
            if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clamp_done_mid%0d: got %b expected 0", i, msb_bus.done_sig); end
        end
        msb_bus.write_sig = 1'b1;
        step();
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clamp_end_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clamp_end_out: got %b expected 0", msb_bus.out_line); end
        step();
    endtask

    task automatic test_ignored_events();
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_1010;
        msb_bus.data_in     = 8'h3a;
        msb_bus.write_count = 4'd8;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
        end
        msb_bus.data_in     = 8'hff;
        msb_bus.write_count = 4'd2;
        msb_bus.start       = 1'b1;
        step();
        msb_bus.start = 1'b0;
        n_compared += 2;
        if (msb_bus.out_line !== exp_bits[5]) begin n_mismatched++; $display("[TB] FAIL restart_hold: got %b expected %b", msb_bus.out_line, exp_bits[5]); end
        if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_done: got %b expected 0", msb_bus.done_sig); end
        for (int i = 3; i < 8; i++) begin
            msb_bus.write_sig = 1'b1;
            step();
            msb_bus.write_sig = 1'b0;
            n_compared++;
            if (msb_bus.out_line !== exp_bits[7-i]) begin n_mismatched++; $display("[TB] FAIL ignored_bit%0d: got %b expected %b", i, msb_bus.out_line, exp_bits[7-i]); end
        end
        msb_bus.write_sig = 1'b1;
        step();
        n_compared++;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ignored_end_done: got %b expected 1", msb_bus.done_sig); end
        step();
        step();
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL idle_write_done: got %b expected 1", msb_bus.done_sig); end
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_write_out: got %b expected 0", msb_bus.out_line); end
        // A write_sig alongside an accepted start must not consume the first bit.
        msb_bus.data_in     = 8'h02;
        msb_bus.write_count = 4'd2;
        msb_bus.start       = 1'b1;
        msb_bus.write_sig   = 1'b1;
        step();
        msb_bus.start     = 1'b0;
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.out_line !== 1'b1) begin n_mismatched++; $display("[TB] FAIL coincident_out: got %b expected 1", msb_bus.out_line); end
        if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL coincident_done: got %b expected 0", msb_bus.done_sig); end
        msb_bus.write_sig = 1'b1;
        step();
        msb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (msb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL coincident_bit1: got %b expected 0", msb_bus.out_line); end
        if (msb_bus.done_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL coincident_mid_done: got %b expected 0", msb_bus.done_sig); end
        msb_bus.write_sig = 1'b1;
        step();
        msb_bus.write_sig = 1'b0;
        n_compared++;
        if (msb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL coincident_end_done: got %b expected 1", msb_bus.done_sig); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_bits;
        exp_bits = 5'b01101;
        lsb_bus.data_in     = 8'h96;
        lsb_bus.write_count = 4'd5;
        lsb_bus.start       = 1'b1;
        step();
        lsb_bus.start = 1'b0;
        n_compared++;
        if (lsb_bus.out_line !== exp_bits[4]) begin n_mismatched++; $display("[TB] FAIL b2b_bit0: got %b expected %b", lsb_bus.out_line, exp_bits[4]); end
        lsb_bus.write_sig = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            n_compared++;
            if (lsb_bus.out_line !== exp_bits[4-i]) begin n_mismatched++; $display("[TB] FAIL b2b_bit%0d: got %b expected %b", i, lsb_bus.out_line, exp_bits[4-i]); end
        end
        step();
        lsb_bus.write_sig = 1'b0;
        n_compared += 2;
        if (lsb_bus.done_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_end_done: got %b expected 1", lsb_bus.done_sig); end
        if (lsb_bus.out_line !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_end_out: got %b expected 0", lsb_bus.out_line); end
        step();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        msb_bus.start = 1'b0; msb_bus.write_sig = 1'b0; msb_bus.data_in = '0; msb_bus.write_count = '0;
        lsb_bus.start = 1'b0; lsb_bus.write_sig = 1'b0; lsb_bus.data_in = '0; lsb_bus.write_count = '0;
        test_reset();
        test_msb_transfer();
        test_reset_abort();
        test_lsb_first();
        test_zero_count();
        test_clamp();
        test_ignored_events();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
